// File: rtl/light_pkg.sv
// Shared types and constants for the intersection light controller:
// state/phase encoding, default durations and counter-width sizing helpers.
package light_pkg;

    typedef enum logic [2:0] {
        RED_TO_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        RED_TO_EW = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        WALK      = 3'd6
    } light_state_t;

    localparam int DEF_GREEN_TICKS   = 64;
    localparam int DEF_YELLOW_TICKS  = 16;
    localparam int DEF_ALL_RED_TICKS = 4;
    localparam int DEF_WALK_TICKS    = 32;
    localparam int DEF_MIN_GREEN     = 16;
    localparam int DEF_CNT_W         = 8;

    localparam logic DIR_NS = 1'b0;
    localparam logic DIR_EW = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Smallest width whose range covers 0..max_ticks-1.
    function automatic int min_cnt_w(input int max_ticks);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < max_ticks) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase counter: restarts at zero on clear and holds once it reaches limit.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    assign at_limit = (count == limit);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (!at_limit) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/intersection_light_ctrl.sv
// Two-direction intersection controller with latched pedestrian request,
// early green termination and an all-red walk phase. Moore outputs.
module intersection_light_ctrl
    import light_pkg::*;
#(
    parameter int GREEN_TICKS   = DEF_GREEN_TICKS,
    parameter int YELLOW_TICKS  = DEF_YELLOW_TICKS,
    parameter int ALL_RED_TICKS = DEF_ALL_RED_TICKS,
    parameter int WALK_TICKS    = DEF_WALK_TICKS,
    parameter int MIN_GREEN     = DEF_MIN_GREEN,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ped_req,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic       walk,
    output logic       ped_pending,
    output logic [2:0] phase
);

    localparam int MAX_TICKS = max4(GREEN_TICKS, YELLOW_TICKS, ALL_RED_TICKS, WALK_TICKS);

    generate
        if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALL_RED_TICKS < 1 || WALK_TICKS < 1 ||
            MIN_GREEN < 1 || MIN_GREEN > GREEN_TICKS || CNT_W < min_cnt_w(MAX_TICKS)) begin : g_bad_params
            $error("intersection_light_ctrl: illegal duration / counter width parameters");
        end
    endgenerate

    light_state_t     state;
    light_state_t     state_next;
    logic             ret_dir;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] limit;
    logic             at_limit;
    logic             min_green_done;
    logic             entering_walk;

    always_comb begin
        limit = '0;
        case (state)
            RED_TO_NS, RED_TO_EW: limit = CNT_W'(ALL_RED_TICKS - 1);
            NS_GREEN, EW_GREEN:   limit = CNT_W'(GREEN_TICKS - 1);
            NS_YELLOW, EW_YELLOW: limit = CNT_W'(YELLOW_TICKS - 1);
            WALK:                 limit = CNT_W'(WALK_TICKS - 1);
            default:              limit = '0;
        endcase
    end

    assign min_green_done = (count >= CNT_W'(MIN_GREEN - 1));

    always_comb begin
        state_next = state;
        case (state)
            RED_TO_NS: if (at_limit) state_next = ped_pending ? WALK : NS_GREEN;
            NS_GREEN:  if (at_limit || (ped_pending && min_green_done)) state_next = NS_YELLOW;
            NS_YELLOW: if (at_limit) state_next = RED_TO_EW;
            RED_TO_EW: if (at_limit) state_next = ped_pending ? WALK : EW_GREEN;
            EW_GREEN:  if (at_limit || (ped_pending && min_green_done)) state_next = EW_YELLOW;
            EW_YELLOW: if (at_limit) state_next = RED_TO_NS;
            WALK:      if (at_limit) state_next = (ret_dir == DIR_NS) ? NS_GREEN : EW_GREEN;
            default:   state_next = RED_TO_NS;
        endcase
    end

    assign entering_walk = (state_next == WALK) && (state != WALK);

    // Every state change restarts the phase count from zero.
    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_next != state),
        .limit    (limit),
        .count    (count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RED_TO_NS;
            ped_pending <= 1'b0;
            ret_dir     <= DIR_NS;
        end else begin
            state <= state_next;
            // Clearing on walk entry takes priority over a same-cycle press.
            if (entering_walk) begin
                ped_pending <= 1'b0;
                ret_dir     <= (state == RED_TO_EW) ? DIR_EW : DIR_NS;
            end else if (state != WALK && ped_req) begin
                ped_pending <= 1'b1;
            end
        end
    end

    assign ns_g  = (state == NS_GREEN);
    assign ns_y  = (state == NS_YELLOW);
    assign ns_r  = !(ns_g || ns_y);
    assign ew_g  = (state == EW_GREEN);
    assign ew_y  = (state == EW_YELLOW);
    assign ew_r  = !(ew_g || ew_y);
    assign walk  = (state == WALK);
    assign phase = state;

endmodule

// File: doc/intersection_light_ctrl.md
Name: intersection_light_ctrl

Overview:
Parametrised two-direction traffic-intersection controller (north-south and east-west) with latched pedestrian request, early green termination and a dedicated all-red walk phase. All phase durations and the counter width are parameters. Single-clock Moore FSM plus a phase counter. Drives lamp and walk signals at the board top level.

Parameters:
GREEN_TICKS, 64, green phase length in cycles (>=1)
YELLOW_TICKS, 16, yellow phase length in cycles (>=1)
ALL_RED_TICKS, 4, all-red clearance length in cycles (>=1)
WALK_TICKS, 32, pedestrian walk phase length in cycles (>=1)
MIN_GREEN, 16, minimum green before a pedestrian request may cut it short (1..GREEN_TICKS)
CNT_W, 8, phase counter width; must hold max(all *_TICKS)-1

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
ped_req  in  1  pedestrian button, level or pulse, sampled every cycle
ns_r  out  1  north-south red lamp
ns_y  out  1  north-south yellow lamp
ns_g  out  1  north-south green lamp
ew_r  out  1  east-west red lamp
ew_y  out  1  east-west yellow lamp
ew_g  out  1  east-west green lamp
walk  out  1  pedestrian walk lamp
ped_pending  out  1  a pedestrian request is latched and not yet served
phase  out  3  current state encoding, for debug

Behaviour:
- One clock, clk. Reset is synchronous and active-high.
- States: RED_TO_NS, NS_GREEN, NS_YELLOW, RED_TO_EW, EW_GREEN, EW_YELLOW, WALK.
- Reset: state=RED_TO_NS, count=0, ped_pending=0, ret_dir=NS. Outputs during reset: ns_r=1, ew_r=1, all others 0.
- Lamps are decoded combinationally from the state register (Moore). Exactly one lamp per direction is lit at all times.
  - RED_TO_x and WALK: both directions red.
  - WALK: walk=1. walk=0 in every other state.
- Counter: count=0 on every state entry, otherwise increments by 1. A phase of length N lasts exactly N cycles (count 0..N-1). The counter never wraps.
- Transitions, evaluated at count==N-1 unless noted:
  - RED_TO_NS -> WALK if ped_pending, with ret_dir=NS; else -> NS_GREEN.
  - NS_GREEN -> NS_YELLOW at count==GREEN_TICKS-1, or early when ped_pending and count>=MIN_GREEN-1.
  - NS_YELLOW -> RED_TO_EW.
  - RED_TO_EW -> WALK if ped_pending, with ret_dir=EW; else -> EW_GREEN.
  - EW_GREEN and EW_YELLOW: mirror of the NS states.
  - EW_YELLOW -> RED_TO_NS.
  - WALK (WALK_TICKS) -> NS_GREEN if ret_dir=NS, else -> EW_GREEN.
- ped_pending:
  - Set on the clock edge after ped_req=1.
  - Cleared on entry to WALK. Clear wins over a simultaneous ped_req.
  - ped_req during WALK is ignored.
  - Early-termination and walk decisions use only the registered ped_pending, giving one cycle of request latency.
- A ped_req arriving during a yellow phase is served in the following all-red phase. The green it would have interrupted is not shortened.
- Reset mid-operation overrides every state, including WALK, and returns to the reset values on the next edge.
- Free-running period with no requests: 2*(ALL_RED_TICKS+GREEN_TICKS+YELLOW_TICKS) = 168 cycles at the defaults.
- Illegal parameter combinations are rejected at elaboration: any *_TICKS==0, MIN_GREEN>GREEN_TICKS, or CNT_W too small.

Decomposition:
- Package light_pkg holds:
  - the state enum typedef (3-bit logic), which is also the phase port encoding
  - default-duration localparams
  - a function for the minimum required CNT_W
- Sub-module phase_timer, parameter CNT_W. Inputs: clk, reset, clear, limit. Outputs: count, at_limit. It is instantiated once. The FSM, ped latch and ret_dir register live in intersection_light_ctrl.

Test Plan:
- Reset, then run 168 cycles with ped_req=0 -> RED_TO_NS 4 cycles, NS green 64, NS yellow 16, all-red 4, EW green 64, EW yellow 16. Never both greens; walk stays 0.
- ped_req pulse at NS_GREEN count=5 -> ped_pending=1 next cycle; NS green lasts 16 cycles; then yellow 16, all-red 4, WALK 32 with walk=1 and ped_pending cleared on entry; then EW_GREEN.
- ped_req pulse at NS_GREEN count=40 -> NS green lasts 42 cycles total, then normal yellow, all-red and WALK.
- ped_req during EW_YELLOW -> EW_GREEN not affected; after RED_TO_NS comes WALK, then NS_GREEN (ret_dir=NS).
- ped_req held high through a whole WALK -> ped_pending stays 0 during WALK; it re-latches only after WALK exits. Next green is cut at MIN_GREEN.
- reset asserted for 1 cycle at EW_GREEN count=30 -> next cycle phase=RED_TO_NS, ns_r=ew_r=1, ped_pending=0; NS green appears 4 cycles after reset is released.
